// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one synchronous single-port memory between instruction fetch and load/store.
// Optional macro ARB_ROUND_ROBIN_EN selects alternating grants instead of data priority.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ADDR_WIDTH-1:0]   i_m_addr_i,
  input  logic                    i_m_rden_i,
  output logic                    i_m_hit_o,
  output logic [DATA_WIDTH-1:0]   i_m_rdata_o,
  input  logic [ADDR_WIDTH-1:0]   d_m_addr_i,
  input  logic                    d_m_rden_i,
  input  logic                    d_m_wren_i,
  input  logic [DATA_WIDTH-1:0]   d_m_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_m_wmask_i,
  output logic                    d_m_hit_o,
  output logic [DATA_WIDTH-1:0]   d_m_rdata_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic                    m_rden_o,
  output logic                    m_wren_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wmask_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  logic                  ireq;
  logic                  dreq;
  logic                  d_read;
  logic                  data_priority;
  logic                  grant_i;
  logic                  grant_d;
  logic                  rsp_i_q;
  logic                  rsp_d_q;
  logic [DATA_WIDTH-1:0] i_hold_q;
  logic [DATA_WIDTH-1:0] d_hold_q;

  assign ireq   = i_m_rden_i;
  assign dreq   = d_m_rden_i | d_m_wren_i;
  // A simultaneous read+write is a write with no read response.
  assign d_read = d_m_rden_i & ~d_m_wren_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 1 = data was granted most recently

  assign data_priority = ~last_grant_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_grant_q <= 1'b0;
    end else if (grant_d) begin
      last_grant_q <= 1'b1;
    end else if (grant_i) begin
      last_grant_q <= 1'b0;
    end
  end
`else
  localparam int unsigned STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);

  logic [STREAK_WIDTH-1:0] streak_q;

  assign data_priority = (streak_q != STREAK_WIDTH'(MAX_DATA_STREAK));

  // Counts data grants that made a pending fetch wait.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !ireq || grant_i) begin
      streak_q <= '0;
    end else if (grant_d && (streak_q != STREAK_WIDTH'(MAX_DATA_STREAK))) begin
      streak_q <= streak_q + STREAK_WIDTH'(1);
    end
  end
`endif

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rstn_i) begin
      if (dreq && (!ireq || data_priority)) begin
        grant_d = 1'b1;
      end else if (ireq) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_m_hit_o = grant_i;
  assign d_m_hit_o = grant_d;

  assign m_addr_o  = grant_d ? d_m_addr_i : i_m_addr_i;
  assign m_wdata_o = grant_d ? d_m_wdata_i : '0;
  assign m_wmask_o = grant_d ? d_m_wmask_i : MASK_WIDTH'(0);
  assign m_rden_o  = grant_i | (grant_d & d_read);
  assign m_wren_o  = grant_d & d_m_wren_i;

  // Track which port owns next cycle's read data and keep the last word per port.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rsp_i_q  <= 1'b0;
      rsp_d_q  <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      rsp_i_q <= grant_i;
      rsp_d_q <= grant_d & d_read;
      if (rsp_i_q) begin
        i_hold_q <= m_rdata_i;
      end
      if (rsp_d_q) begin
        d_hold_q <= m_rdata_i;
      end
    end
  end

  assign i_m_rdata_o = rsp_i_q ? m_rdata_i : i_hold_q;
  assign d_m_rdata_o = rsp_d_q ? m_rdata_i : d_hold_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: stimulus queues per-cycle expectations, a monitor checks them.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_addr;
  logic        i_rden;
  logic        i_hit;
  logic [31:0] i_rdata;
  logic [31:0] d_addr;
  logic        d_rden;
  logic        d_wren;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_hit;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic        m_rden;
  logic        m_wren;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    bit          ih, dh, mrd, mwr;
    bit          chk_addr;
    logic [31:0] maddr;
    logic [3:0]  mmask;
    logic [31:0] mwdata;
    bit          chk_ir;
    logic [31:0] ir;
    bit          chk_dr;
    logic [31:0] dr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  imem_dmem_arbiter dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .i_m_addr_i  (i_addr),
    .i_m_rden_i  (i_rden),
    .i_m_hit_o   (i_hit),
    .i_m_rdata_o (i_rdata),
    .d_m_addr_i  (d_addr),
    .d_m_rden_i  (d_rden),
    .d_m_wren_i  (d_wren),
    .d_m_wdata_i (d_wdata),
    .d_m_wmask_i (d_wmask),
    .d_m_hit_o   (d_hit),
    .d_m_rdata_o (d_rdata),
    .m_addr_o    (m_addr),
    .m_rden_o    (m_rden),
    .m_wren_o    (m_wren),
    .m_wdata_o   (m_wdata),
    .m_wmask_o   (m_wmask),
    .m_rdata_i   (m_rdata)
  );

  // Single-port synchronous memory, one-cycle read latency.
  always @(posedge clk) begin
    if (m_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (m_wmask[b]) mem[m_addr[11:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end
    end
    if (m_rden) m_rdata <= mem[m_addr[11:2]];
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation record per clock cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "i_hit",  32'(i_hit),  32'(e.ih));
      chk(e.name, "d_hit",  32'(d_hit),  32'(e.dh));
      chk(e.name, "m_rden", 32'(m_rden), 32'(e.mrd));
      chk(e.name, "m_wren", 32'(m_wren), 32'(e.mwr));
      if (e.chk_addr) begin
        chk(e.name, "m_addr",  m_addr,       e.maddr);
        chk(e.name, "m_wmask", 32'(m_wmask), 32'(e.mmask));
        chk(e.name, "m_wdata", m_wdata,      e.mwdata);
      end
      if (e.chk_ir) chk(e.name, "i_rdata", i_rdata, e.ir);
      if (e.chk_dr) chk(e.name, "d_rdata", d_rdata, e.dr);
    end
  end

  function automatic exp_t ex(input string n, input bit ih, input bit dh, input bit mrd, input bit mwr,
                              input bit ca, input logic [31:0] ma, input logic [3:0] mm, input logic [31:0] mw,
                              input bit ci, input logic [31:0] ir, input bit cd, input logic [31:0] dr);
    exp_t e;
    e.name = n; e.ih = ih; e.dh = dh; e.mrd = mrd; e.mwr = mwr;
    e.chk_addr = ca; e.maddr = ma; e.mmask = mm; e.mwdata = mw;
    e.chk_ir = ci; e.ir = ir; e.chk_dr = cd; e.dr = dr;
    return e;
  endfunction

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] wd, input logic [3:0] wm, input exp_t e);
    @(posedge clk);
    #1;
    rstn = r; i_rden = ir; i_addr = ia;
    d_rden = dr; d_wren = dw; d_addr = da; d_wdata = wd; d_wmask = wm;
    exp_q.push_back(e);
  endtask

  initial begin
    string       pat;
    logic [31:0] hold_i;
    logic [31:0] hold_d;
    bit          gi;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[32'h100 >> 2] = 32'h00A00093;
    mem[32'h104 >> 2] = 32'h11111111;
    mem[32'h108 >> 2] = 32'h33333333;
    mem[32'h200 >> 2] = 32'h12345678;
    mem[32'h204 >> 2] = 32'h22222222;
    m_rdata = 32'h0;
    rstn = 1'b0; i_rden = 1'b0; i_addr = 32'h0;
    d_rden = 1'b0; d_wren = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;

    // Reset with both ports requesting: no grants, no memory enables.
    for (int k = 0; k < 2; k++)
      step(0, 1, 32'h100, 1, 0, 32'h200, 0, 0, ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, ex("post_reset", 0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 1, 0));

    // Fetch only, then data writes while the instruction is held.
    step(1, 1, 32'h100, 0, 0, 32'h0, 0, 0, ex("fetch", 1, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step(1, 0, 32'h0, 0, 1, 32'h380, 32'hCAFEF00D, 4'hF,
           ex("fetch_hold", 0, 1, 0, 1, 1, 32'h380, 4'hF, 32'hCAFEF00D, 1, 32'h00A00093, 1, 0));

    // Second fetch, then a conflict that data wins.
    step(1, 1, 32'h108, 0, 0, 32'h0, 0, 0, ex("fetch2", 1, 0, 1, 0, 1, 32'h108, 0, 0, 1, 32'h00A00093, 0, 0));
    step(1, 1, 32'h104, 1, 0, 32'h200, 0, 0, ex("conflict", 0, 1, 1, 0, 1, 32'h200, 0, 0, 1, 32'h33333333, 0, 0));
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, ex("conflict_rsp", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333, 1, 32'h12345678));

    // Masked write leaves both read outputs unchanged.
    step(1, 0, 32'h0, 0, 1, 32'h300, 32'hDEADBEEF, 4'b0011,
         ex("write", 0, 1, 0, 1, 1, 32'h300, 4'b0011, 32'hDEADBEEF, 1, 32'h33333333, 1, 32'h12345678));
    step(1, 1, 32'h104, 0, 0, 32'h0, 0, 0, ex("write_after", 1, 0, 1, 0, 1, 32'h104, 0, 0, 1, 32'h33333333, 1, 32'h12345678));

    // Reset while a fetch response is outstanding drops it.
    step(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, ex("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, ex("mid_reset_after", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));

    // Both ports requesting continuously.
`ifdef ARB_ROUND_ROBIN_EN
    pat = "DIDIDIDIDI";
`else
    pat = "DDDDIDDDDI";
`endif
    hold_i = 32'h0;
    hold_d = 32'h0;
    for (int k = 0; k < pat.len(); k++) begin
      if (k > 0) begin
        if (pat[k-1] == "I") hold_i = 32'h11111111;
        else hold_d = 32'h22222222;
      end
      gi = (pat[k] == "I");
      step(1, 1, 32'h104, 1, 0, 32'h204, 0, 0,
           ex($sformatf("streak%0d", k), gi, !gi, 1, 0, 1, gi ? 32'h104 : 32'h204, 0, 0, 1, hold_i, 1, hold_d));
    end
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, ex("streak_end", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, 1, 32'h22222222));

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
